// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register unit with delayed divider commit and stall generation
// Optional sticky divide-by-zero flag enabled by defining DIV_ZERO_TRAP_EN.
module hilo_unit #(
    parameter int unsigned DIV_LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_start,
    input  logic [31:0] divisor,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    input  logic        mult_wr,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        mfhi,
    input  logic        mflo,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        busy,
    output logic        div_by_zero,
    input  logic        div_zero_clr
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] LAT_M1 = 8'(DIV_LATENCY - 1);

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [31:0] hi, hi_next, lo, lo_next;
    logic [31:0] hi_pend, hi_pend_next, lo_pend, lo_pend_next;
    logic        commit;

    // Priority in IDLE: divide issue, then multiply result, then moves.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        hi_next      = hi;
        lo_next      = lo;
        hi_pend_next = hi_pend;
        lo_pend_next = lo_pend;
        commit       = 1'b0;
        case (state)
            IDLE: begin
                if (div_start) begin
                    lo_pend_next = quotient;
                    hi_pend_next = remainder;
                    cnt_next     = LAT_M1;
                    state_next   = BUSY;
                end else if (mult_wr) begin
                    hi_next = mult_hi;
                    lo_next = mult_lo;
                end else begin
                    if (mthi) hi_next = wdata;
                    if (mtlo) lo_next = wdata;
                end
            end
            BUSY: begin
                if (cnt != 8'd0) begin
                    cnt_next = cnt - 8'd1;
                end else begin
                    commit     = 1'b1;
                    hi_next    = hi_pend;
                    lo_next    = lo_pend;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_pend <= 32'd0;
            lo_pend <= 32'd0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            hi      <= hi_next;
            lo      <= lo_next;
            hi_pend <= hi_pend_next;
            lo_pend <= lo_pend_next;
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    logic zero_pend;
    logic flag_q;

    // A commit that sets the flag takes precedence over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_pend <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            if (state == IDLE && div_start) zero_pend <= (divisor == 32'd0);
            if (commit && zero_pend)        flag_q    <= 1'b1;
            else if (div_zero_clr)          flag_q    <= 1'b0;
        end
    end

    assign div_by_zero = flag_q;
`else
    logic unused_trap_inputs;
    assign unused_trap_inputs = ^{divisor, div_zero_clr, commit};
    assign div_by_zero        = 1'b0;
`endif

    assign busy  = (state == BUSY);
    assign stall = busy & (div_start | mult_wr | mthi | mtlo | mfhi | mflo);
    assign rdata = mfhi ? hi : (mflo ? lo : 32'd0);

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - self-checking bench for hilo_unit with a read-data scoreboard queue
module tb_hilo_unit;

    localparam int LAT = 8;

`ifdef DIV_ZERO_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_start, mult_wr, mthi, mtlo, mfhi, mflo, div_zero_clr;
    logic [31:0] divisor, quotient, remainder, mult_hi, mult_lo, wdata;
    logic [31:0] rdata;
    logic        stall, busy, div_by_zero;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          cycles;

    hilo_unit #(.DIV_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .div_start(div_start), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .mult_wr(mult_wr),
        .mult_hi(mult_hi), .mult_lo(mult_lo), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .mfhi(mfhi), .mflo(mflo), .rdata(rdata), .stall(stall),
        .busy(busy), .div_by_zero(div_by_zero), .div_zero_clr(div_zero_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        div_start = 0; mult_wr = 0; mthi = 0; mtlo = 0; mfhi = 0; mflo = 0;
        div_zero_clr = 0; divisor = 32'd1; quotient = 0; remainder = 0;
        mult_hi = 0; mult_lo = 0; wdata = 0;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 0;
        mfhi = 1;
        exp_q.push_back(32'd0);
        #2;
        n_cmp++;
        if (busy !== 1'b0 || stall !== 1'b0 || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: busy=%b stall=%b dbz=%b required 0/0/0", busy, stall, div_by_zero);
        end
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL reset_rdata: got %h required %h", rdata, e); end
        tick(); tick();
        rst_n = 1;
        mfhi = 0;
        tick();
    endtask

    task automatic test_div();
        clear_in();
        div_start = 1; quotient = 32'h7; remainder = 32'h2; divisor = 32'h3;
        tick();
        clear_in();
        cycles = 0;
        while (busy && cycles < 100) begin cycles++; tick(); end
        n_cmp++;
        if (cycles !== LAT) begin n_err++; $display("FAIL div_busy_cycles: got %0d required %0d", cycles, LAT); end
        mflo = 1; exp_q.push_back(32'h7); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL div_lo: got %h required %h", rdata, e); end
        mfhi = 1; exp_q.push_back(32'h2); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL div_hi_mfhi_wins: got %h required %h", rdata, e); end
        clear_in();
        tick();
    endtask

    task automatic test_stall();
        clear_in();
        div_start = 1; quotient = 32'h11; remainder = 32'h22;
        tick();
        clear_in();
        tick();
        mflo = 1; #1;
        cycles = 0;
        while (stall && cycles < 100) begin cycles++; tick(); end
        n_cmp++;
        if (cycles !== LAT - 1) begin n_err++; $display("FAIL stall_cycles: got %0d required %0d", cycles, LAT - 1); end
        exp_q.push_back(32'h11);
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL stall_new_lo: got %h required %h", rdata, e); end
        clear_in();
        tick();
    endtask

    task automatic test_mult_mt();
        clear_in();
        mult_wr = 1; mult_hi = 32'h12345678; mult_lo = 32'h9ABCDEF0;
        tick();
        clear_in();
        mfhi = 1; exp_q.push_back(32'h12345678); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL mult_hi: got %h required %h", rdata, e); end
        mfhi = 0; mflo = 1; exp_q.push_back(32'h9ABCDEF0); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL mult_lo: got %h required %h", rdata, e); end
        mflo = 0; mfhi = 1; mthi = 1; mtlo = 1; wdata = 32'hDEADBEEF;
        exp_q.push_back(32'h12345678); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL mt_no_bypass: got %h required %h", rdata, e); end
        tick();
        clear_in();
        mfhi = 1; exp_q.push_back(32'hDEADBEEF); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL mthi: got %h required %h", rdata, e); end
        mfhi = 0; mflo = 1; exp_q.push_back(32'hDEADBEEF); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL mtlo: got %h required %h", rdata, e); end
        clear_in();
        tick();
    endtask

    task automatic test_priority();
        clear_in();
        div_start = 1; quotient = 32'hAAAA; remainder = 32'hBBBB; divisor = 32'h5;
        mult_wr = 1; mult_hi = 32'h1; mult_lo = 32'h2; mthi = 1; wdata = 32'h3;
        tick();
        clear_in();
        mfhi = 1; exp_q.push_back(32'hDEADBEEF); #1;
        n_cmp++;
        if (busy !== 1'b1 || stall !== 1'b1) begin n_err++; $display("FAIL prio_busy: busy=%b stall=%b required 1/1", busy, stall); end
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL prio_hi_unchanged: got %h required %h", rdata, e); end
        cycles = 0;
        while (busy && cycles < 100) begin cycles++; tick(); end
        exp_q.push_back(32'hBBBB);
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL prio_div_hi: got %h required %h", rdata, e); end
        mfhi = 0; mflo = 1; exp_q.push_back(32'hAAAA); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL prio_div_lo: got %h required %h", rdata, e); end
        clear_in();
        tick();
    endtask

    task automatic test_div_zero();
        clear_in();
        div_start = 1; divisor = 32'd0; quotient = 32'd0; remainder = 32'd0;
        tick();
        clear_in();
        cycles = 0;
        while (busy && cycles < 100) begin cycles++; tick(); end
        mfhi = 1; exp_q.push_back(32'd0); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL dz_hi: got %h required %h", rdata, e); end
        mfhi = 0; mflo = 1; exp_q.push_back(32'd0); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL dz_lo: got %h required %h", rdata, e); end
        n_cmp++;
        if (div_by_zero !== TRAP) begin n_err++; $display("FAIL dz_flag_set: got %b required %b", div_by_zero, TRAP); end
        clear_in();
        div_zero_clr = 1;
        tick();
        div_zero_clr = 0;
        n_cmp++;
        if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_flag_clr: got %b required 0", div_by_zero); end
        // clear held through the whole division: the commit-time set must still win
        div_start = 1; divisor = 32'd0; div_zero_clr = 1;
        tick();
        div_start = 0;
        cycles = 0;
        while (busy && cycles < 100) begin cycles++; tick(); end
        n_cmp++;
        if (div_by_zero !== TRAP) begin n_err++; $display("FAIL dz_set_wins: got %b required %b", div_by_zero, TRAP); end
        tick();
        n_cmp++;
        if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_clr_after: got %b required 0", div_by_zero); end
        clear_in();
        tick();
    endtask

    task automatic test_reset_mid();
        clear_in();
        mult_wr = 1; mult_hi = 32'h55; mult_lo = 32'h66;
        tick();
        clear_in();
        div_start = 1; quotient = 32'h9; remainder = 32'h8; divisor = 32'h2;
        tick();
        clear_in();
        tick(); tick();
        rst_n = 0; #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        mfhi = 1; exp_q.push_back(32'd0); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL rstmid_hi: got %h required %h", rdata, e); end
        mfhi = 0; mflo = 1; exp_q.push_back(32'd0); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL rstmid_lo: got %h required %h", rdata, e); end
        clear_in();
        tick();
        rst_n = 1;
        repeat (LAT + 2) tick();
        mfhi = 1; exp_q.push_back(32'd0); #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_late_busy: got %b required 0", busy); end
        e = exp_q.pop_front(); n_cmp++;
        if (rdata !== e) begin n_err++; $display("FAIL rstmid_no_commit: got %h required %h", rdata, e); end
        clear_in();
    endtask

    initial begin
        test_reset();
        test_div();
        test_stall();
        test_mult_mt();
        test_priority();
        test_div_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
